dmem_responder: RTL and testbench

Cycle-accurate responder for the core's data-memory request/response interface, standing in for the L1 data cache in subsystem benches. It accepts requests in stage s0 and takes store data and kill in s1. In s2 it returns a response, a nack or an access exception. Storage is a local 64-bit-wide byte-enabled RAM mapped at a fixed base address.

---
 rtl/dmem_resp_pkg.sv | 80 ++++++++
 rtl/dmem_responder_if.sv | 61 ++++++
 rtl/dmem_resp_ram.sv | 26 ++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the data-memory responder: command/type codes,
// pipeline stage records and the load-extend / lane-mask helpers.
package dmem_resp_pkg;

    localparam logic [4:0] M_XRD = 5'd0;
    localparam logic [4:0] M_XWR = 5'd1;

    localparam logic [2:0] MT_B  = 3'd0;
    localparam logic [2:0] MT_H  = 3'd1;
    localparam logic [2:0] MT_W  = 3'd2;
    localparam logic [2:0] MT_D  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd4;
    localparam logic [2:0] MT_HU = 3'd5;
    localparam logic [2:0] MT_WU = 3'd6;

    typedef struct packed {
        logic        valid;
        logic [39:0] addr;
        logic [6:0]  tag;
        logic [4:0]  cmd;
        logic [2:0]  typ;
    } s1_t;

    typedef struct packed {
        logic        valid;
        logic [39:0] addr;
        logic [6:0]  tag;
        logic [4:0]  cmd;
        logic [2:0]  typ;
        logic [63:0] data;
    } s2_t;

    typedef enum logic [2:0] {
        OUT_NONE,
        OUT_NACK,
        OUT_AE,
        OUT_MA,
        OUT_RESP
    } outcome_e;

    function automatic logic [63:0] extend_load(input logic [63:0] word,
                                                input logic [2:0]  lane,
                                                input logic [2:0]  typ);
        logic [63:0] sh;
        logic [63:0] res;
        sh = word >> {lane, 3'b000};
        case (typ[1:0])
            2'd0:    res = typ[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    res = typ[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    res = typ[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                             input logic [2:0] lane);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << lane;
    endfunction

    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [2:0] lane);
        logic res;
        case (size)
            2'd0:    res = 1'b0;
            2'd1:    res = lane[0];
            2'd2:    res = |lane[1:0];
            default: res = |lane;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-memory request/response bundle; slave is the memory side,
// master is the requesting core.
interface dmem_responder_if;

    logic        req_ready;
    logic        req_valid;
    logic [39:0] req_bits_addr;
    logic [6:0]  req_bits_tag;
    logic [4:0]  req_bits_cmd;
    logic [2:0]  req_bits_typ;
    logic        req_bits_phys;
    logic        s1_kill;
    logic [63:0] s1_data_data;
    logic [7:0]  s1_data_mask;
    logic        s2_nack;
    logic        resp_valid;
    logic [6:0]  resp_bits_tag;
    logic [2:0]  resp_bits_typ;
    logic [63:0] resp_bits_data;
    logic        resp_bits_replay;
    logic        resp_bits_has_data;
    logic [63:0] resp_bits_data_word_bypass;
    logic        replay_next;
    logic        s2_xcpt_ma_ld;
    logic        s2_xcpt_ma_st;
    logic        s2_xcpt_pf_ld;
    logic        s2_xcpt_pf_st;
    logic        s2_xcpt_ae_ld;
    logic        s2_xcpt_ae_st;
    logic        invalidate_lr;
    logic        ordered;

    modport slave (
        output req_ready,
        input  req_valid, req_bits_addr, req_bits_tag, req_bits_cmd,
               req_bits_typ, req_bits_phys,
        input  s1_kill, s1_data_data, s1_data_mask,
        output s2_nack, resp_valid, resp_bits_tag, resp_bits_typ,
               resp_bits_data, resp_bits_replay, resp_bits_has_data,
               resp_bits_data_word_bypass, replay_next,
        output s2_xcpt_ma_ld, s2_xcpt_ma_st, s2_xcpt_pf_ld, s2_xcpt_pf_st,
               s2_xcpt_ae_ld, s2_xcpt_ae_st,
        input  invalidate_lr,
        output ordered
    );

    modport master (
        input  req_ready,
        output req_valid, req_bits_addr, req_bits_tag, req_bits_cmd,
               req_bits_typ, req_bits_phys,
        output s1_kill, s1_data_data, s1_data_mask,
        input  s2_nack, resp_valid, resp_bits_tag, resp_bits_typ,
               resp_bits_data, resp_bits_replay, resp_bits_has_data,
               resp_bits_data_word_bypass, replay_next,
        input  s2_xcpt_ma_ld, s2_xcpt_ma_st, s2_xcpt_pf_ld, s2_xcpt_pf_st,
               s2_xcpt_ae_ld, s2_xcpt_ae_st,
        output invalidate_lr,
        input  ordered
    );

endinterface

// File: rtl/dmem_resp_ram.sv
// 64-bit wide byte-enabled RAM with asynchronous read; a write lands at the
// clock edge, so a read in the following cycle already sees it.
module dmem_resp_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clock,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [7:0]                     be,
    input  logic [63:0]                    wdata,
    output logic [63:0]                    rdata
);

    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-cache stand-in: s0 accept, s1 data/kill, s2 response/nack/exception.
// Optional DMEM_RESP_NACK_INJECT_EN adds LFSR-driven pseudo-random nacks.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter logic [39:0] BASE_ADDR   = 40'h60000000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input logic              clock,
    input logic              reset,
    dmem_responder_if.slave  dmem
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [40:0] END_ADDR = {1'b0, BASE_ADDR} + (41'(DEPTH_WORDS) << 3);

    s1_t s1_q;
    s2_t s2_q;

    outcome_e    outcome;
    logic        inject;
    logic        is_load;
    logic        in_range;
    logic [2:0]  lane;
    logic [1:0]  size;
    logic [39:0] rel;
    logic [IDX_W-1:0] idx;
    logic        ram_we;
    logic [7:0]  ram_be;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;

    assign dmem.req_ready = !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q.valid <= dmem.req_valid && dmem.req_ready;
            s1_q.addr  <= dmem.req_bits_addr;
            s1_q.tag   <= dmem.req_bits_tag;
            s1_q.cmd   <= dmem.req_bits_cmd;
            s1_q.typ   <= dmem.req_bits_typ;
            s2_q.valid <= s1_q.valid && !dmem.s1_kill;
            s2_q.addr  <= s1_q.addr;
            s2_q.tag   <= s1_q.tag;
            s2_q.cmd   <= s1_q.cmd;
            s2_q.typ   <= s1_q.typ;
            s2_q.data  <= dmem.s1_data_data;
        end
    end

`ifdef DMEM_RESP_NACK_INJECT_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign inject = (lfsr_q[3:0] == 4'h0);
`else
    assign inject = 1'b0;
`endif

    assign is_load  = (s2_q.cmd == M_XRD);
    assign lane     = s2_q.addr[2:0];
    assign size     = s2_q.typ[1:0];
    assign rel      = s2_q.addr - BASE_ADDR;
    assign idx      = rel[IDX_W+2:3];
    assign in_range = ({1'b0, s2_q.addr} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, s2_q.addr} < END_ADDR);

    // Reset gates the outcome so a request caught in s2 during reset is dropped.
    always_comb begin
        outcome = OUT_NONE;
        if (s2_q.valid && !reset) begin
            if (s2_q.cmd != M_XRD && s2_q.cmd != M_XWR) outcome = OUT_NACK;
            else if (!in_range)                          outcome = OUT_AE;
            else if (misaligned(size, lane))             outcome = OUT_MA;
            else if (inject)                             outcome = OUT_NACK;
            else                                         outcome = OUT_RESP;
        end
    end

    assign ram_we    = (outcome == OUT_RESP) && !is_load;
    assign ram_be    = lane_mask(size, lane);
    assign ram_wdata = s2_q.data << {lane, 3'b000};

    dmem_resp_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (idx),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        dmem.s2_nack                    = 1'b0;
        dmem.resp_valid                 = 1'b0;
        dmem.resp_bits_tag              = '0;
        dmem.resp_bits_typ              = '0;
        dmem.resp_bits_data             = '0;
        dmem.resp_bits_has_data         = 1'b0;
        dmem.resp_bits_data_word_bypass = '0;
        dmem.s2_xcpt_ma_ld              = 1'b0;
        dmem.s2_xcpt_ma_st              = 1'b0;
        dmem.s2_xcpt_ae_ld              = 1'b0;
        dmem.s2_xcpt_ae_st              = 1'b0;
        case (outcome)
            OUT_NACK: dmem.s2_nack = 1'b1;
            OUT_AE: begin
                dmem.s2_xcpt_ae_ld = is_load;
                dmem.s2_xcpt_ae_st = !is_load;
            end
            OUT_MA: begin
                dmem.s2_xcpt_ma_ld = is_load;
                dmem.s2_xcpt_ma_st = !is_load;
            end
            OUT_RESP: begin
                dmem.resp_valid                 = 1'b1;
                dmem.resp_bits_tag              = s2_q.tag;
                dmem.resp_bits_typ              = s2_q.typ;
                dmem.resp_bits_has_data         = is_load;
                dmem.resp_bits_data             = is_load ? extend_load(ram_rdata, lane, s2_q.typ) : '0;
                dmem.resp_bits_data_word_bypass = ram_rdata;
            end
            default: ;
        endcase
    end

    assign dmem.resp_bits_replay = 1'b0;
    assign dmem.replay_next      = 1'b0;
    assign dmem.s2_xcpt_pf_ld    = 1'b0;
    assign dmem.s2_xcpt_pf_st    = 1'b0;
    assign dmem.ordered          = reset || (!s1_q.valid && !s2_q.valid);

    logic unused_bits;
    assign unused_bits = ^{dmem.req_bits_phys, dmem.s1_data_mask, dmem.invalidate_lr,
                           rel[39:IDX_W+3], rel[2:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected s2
// outcomes; a negedge monitor pops and compares them as the DUT responds.
module tb_dmem_responder;
    import dmem_resp_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dmem_responder_if dmem ();

    dmem_responder #(
        .BASE_ADDR(40'h60000000),
        .DEPTH_WORDS(1024)
    ) dut (
        .clock (clock),
        .reset (reset),
        .dmem  (dmem)
    );

    typedef enum {K_RESP, K_NACK, K_MA_LD, K_MA_ST, K_AE_LD, K_AE_ST} kind_e;

    typedef struct {
        int          due;
        kind_e       kind;
        logic [6:0]  tag;
        logic [2:0]  typ;
        logic        has;
        logic [63:0] data;
    } exp_t;

    exp_t        q[$];
    logic [63:0] pend_data = '0;
    logic        pend_kill = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [9:0] kind_flags(input kind_e k);
        case (k)
            K_RESP:  return 10'b1000000000;
            K_NACK:  return 10'b0100000000;
            K_MA_LD: return 10'b0010000000;
            K_MA_ST: return 10'b0001000000;
            K_AE_LD: return 10'b0000100000;
            default: return 10'b0000010000;
        endcase
    endfunction

    logic [9:0] act_flags;
    exp_t       e;

    always @(negedge clock) begin
        act_flags = {dmem.resp_valid, dmem.s2_nack, dmem.s2_xcpt_ma_ld, dmem.s2_xcpt_ma_st,
                     dmem.s2_xcpt_ae_ld, dmem.s2_xcpt_ae_st, dmem.s2_xcpt_pf_ld,
                     dmem.s2_xcpt_pf_st, dmem.resp_bits_replay, dmem.replay_next};
        if (q.size() != 0 && q[0].due < cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_outcome: tag %0d due cycle %0d not seen by cycle %0d", e.tag, e.due, cyc);
        end
        if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("outcome_flags", 64'(act_flags), 64'(kind_flags(e.kind)));
            if (e.kind == K_RESP) begin
                check("resp_tag", 64'(dmem.resp_bits_tag), 64'(e.tag));
                check("resp_typ", 64'(dmem.resp_bits_typ), 64'(e.typ));
                check("resp_has_data", 64'(dmem.resp_bits_has_data), 64'(e.has));
                if (e.has) check("resp_data", dmem.resp_bits_data, e.data);
            end
        end else if (act_flags != '0) begin
            check("unexpected_outcome", 64'(act_flags), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one request; s1 data/kill for the previous request go out in the same cycle.
    task automatic issue(input logic [4:0] cmd, input logic [2:0] typ, input logic [39:0] addr,
                         input logic [6:0] tag, input logic [63:0] sdata, input logic kill,
                         input kind_e k, input logic [63:0] edata, input bit push);
        dmem.req_valid     = 1'b1;
        dmem.req_bits_cmd  = cmd;
        dmem.req_bits_typ  = typ;
        dmem.req_bits_addr = addr;
        dmem.req_bits_tag  = tag;
        dmem.s1_data_data  = pend_data;
        dmem.s1_kill       = pend_kill;
        pend_data = sdata;
        pend_kill = kill;
        if (push) q.push_back('{due: cyc + 2, kind: k, tag: tag, typ: typ,
                                has: (cmd == M_XRD), data: edata});
        tick();
    endtask

    task automatic idle();
        dmem.req_valid    = 1'b0;
        dmem.s1_data_data = pend_data;
        dmem.s1_kill      = pend_kill;
        pend_data = '0;
        pend_kill = 1'b0;
        tick();
    endtask

    initial begin
        dmem.req_valid     = 1'b0;
        dmem.req_bits_addr = '0;
        dmem.req_bits_tag  = '0;
        dmem.req_bits_cmd  = '0;
        dmem.req_bits_typ  = '0;
        dmem.req_bits_phys = 1'b0;
        dmem.s1_kill       = 1'b0;
        dmem.s1_data_data  = '0;
        dmem.s1_data_mask  = '0;
        dmem.invalidate_lr = 1'b0;

        repeat (3) tick();
        check("reset_req_ready", 64'(dmem.req_ready), 64'd0);
        check("reset_ordered", 64'(dmem.ordered), 64'd1);
        check("reset_resp_valid", 64'(dmem.resp_valid), 64'd0);
        reset = 1'b0;
        idle();
        check("post_reset_req_ready", 64'(dmem.req_ready), 64'd1);
        check("post_reset_ordered", 64'(dmem.ordered), 64'd1);

        // Store then loads with each extension flavour.
        issue(M_XWR, MT_D,  40'h60000000, 7'd1, 64'h1122334455667788, 0, K_RESP, '0, 1);
        issue(M_XRD, MT_D,  40'h60000000, 7'd2, '0, 0, K_RESP, 64'h1122334455667788, 1);
        issue(M_XRD, MT_B,  40'h60000000, 7'd3, '0, 0, K_RESP, 64'hFFFFFFFFFFFFFF88, 1);
        issue(M_XRD, MT_BU, 40'h60000000, 7'd4, '0, 0, K_RESP, 64'h0000000000000088, 1);
        issue(M_XRD, MT_B,  40'h60000007, 7'd5, '0, 0, K_RESP, 64'h0000000000000011, 1);

        // Misalignment and address range.
        issue(M_XRD, MT_W,  40'h60000002, 7'd6, '0, 0, K_MA_LD, '0, 1);
        issue(M_XWR, MT_H,  40'h60000001, 7'd7, 64'hFFFF, 0, K_MA_ST, '0, 1);
        issue(M_XWR, MT_D,  40'h60001FF8, 7'd8, 64'hCAFEF00D12345678, 0, K_RESP, '0, 1);
        issue(M_XWR, MT_D,  40'h5FFFFFF8, 7'd9, 64'hDEADDEADDEADDEAD, 0, K_AE_ST, '0, 1);
        issue(M_XRD, MT_D,  40'h60001FF8, 7'd10, '0, 0, K_RESP, 64'hCAFEF00D12345678, 1);
        issue(M_XRD, MT_B,  40'h60002000, 7'd11, '0, 0, K_AE_LD, '0, 1);
        issue(M_XRD, MT_D,  40'h60000000, 7'd12, '0, 0, K_RESP, 64'h1122334455667788, 1);

        // Killed store, then a byte store with junk in the upper data bits.
        issue(M_XWR, MT_D,  40'h60000010, 7'd13, 64'hA5A5A5A5A5A5A5A5, 0, K_RESP, '0, 1);
        issue(M_XWR, MT_W,  40'h60000010, 7'd14, 64'hDEADBEEF, 1, K_RESP, '0, 0);
        issue(M_XRD, MT_D,  40'h60000010, 7'd15, '0, 0, K_RESP, 64'hA5A5A5A5A5A5A5A5, 1);
        issue(M_XWR, MT_B,  40'h60000013, 7'd16, 64'hFFFFFFFFFFFFFF5A, 0, K_RESP, '0, 1);
        issue(M_XRD, MT_D,  40'h60000010, 7'd17, '0, 0, K_RESP, 64'hA5A5A5A55AA5A5A5, 1);
        repeat (3) idle();
        check("drained_ordered", 64'(dmem.ordered), 64'd1);

        // Eight back-to-back loads.
        for (int i = 0; i < 8; i++) begin
            issue(M_XRD, MT_D, 40'h60000000, 7'(i), '0, 0, K_RESP, 64'h1122334455667788, 1);
            check("b2b_ordered_busy", 64'(dmem.ordered), 64'd0);
        end
        idle();
        check("b2b_ordered_last", 64'(dmem.ordered), 64'd0);
        idle();
        check("b2b_ordered_done", 64'(dmem.ordered), 64'd1);

        // Store immediately followed by a load of the same word.
        issue(M_XWR, MT_H,  40'h60000004, 7'd20, 64'hBEEF, 0, K_RESP, '0, 1);
        issue(M_XRD, MT_D,  40'h60000000, 7'd21, '0, 0, K_RESP, 64'h1122BEEF55667788, 1);
        issue(M_XRD, MT_H,  40'h60000004, 7'd22, '0, 0, K_RESP, 64'hFFFFFFFFFFFFBEEF, 1);
        issue(M_XRD, MT_WU, 40'h60000004, 7'd23, '0, 0, K_RESP, 64'h000000001122BEEF, 1);
        issue(M_XRD, MT_HU, 40'h60000004, 7'd24, '0, 0, K_RESP, 64'h000000000000BEEF, 1);

        // Unsupported command.
        issue(5'h02, MT_D,  40'h60000000, 7'd25, '0, 0, K_NACK, '0, 1);

        // Reset during the s1 cycle of a store.
        issue(M_XWR, MT_D,  40'h60000008, 7'd26, 64'h0, 0, K_RESP, '0, 1);
        repeat (3) idle();
        issue(M_XWR, MT_D,  40'h60000008, 7'd27, 64'hFFFFFFFFFFFFFFFF, 0, K_RESP, '0, 0);
        reset = 1'b1;
        idle();
        check("midreset_req_ready", 64'(dmem.req_ready), 64'd0);
        check("midreset_ordered", 64'(dmem.ordered), 64'd1);
        reset = 1'b0;
        idle();
        issue(M_XRD, MT_D,  40'h60000008, 7'd28, '0, 0, K_RESP, 64'h0, 1);

        repeat (4) idle();
        check("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
